serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract controller. Sequences one shared 1-bit full-adder

---
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller.
// A single 1-bit full adder is stepped over WIDTH cycles, LSB first, with a
// registered carry. Requester handshake: start (sampled in IDLE), busy, done.
// Subtraction is a + ~b + 1, so cout is the unsigned no-borrow flag.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] acc_next;

  // One full-adder slice on the current LSBs and the registered carry.
  assign bit_sum   = sa_q[0] ^ sb_q[0] ^ c_q;
  assign bit_carry = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

  // New result bit enters at the MSB end; after WIDTH steps the LSB has
  // travelled down to bit 0.
  if (WIDTH == 1) begin : g_acc_w1
    assign acc_next = bit_sum;
  end else begin : g_acc_wn
    assign acc_next = {bit_sum, acc_q[WIDTH-1:1]};
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves a latch.
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    count_d = count_q;
    c_d     = c_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          count_d = '0;
        end
      end
      S_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        c_d     = bit_carry;
        acc_d   = acc_next;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          // Final step publishes the result; sum/cout change only here.
          sum_d   = acc_next;
          cout_d  = bit_carry;
          count_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here; requests are not queued.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand shifters are plain flops, so they are reset along with
    // the control state rather than left to hold stale operands.
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for the main
// scenarios and a 1-bit instance for the full-adder truth table.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int tests_run = 0;
  int tests_failed = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start8),
    .sub  (sub8),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start1),
    .sub  (sub1),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1),
    .cout (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    tests_run++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy8, done8, cout8, sum8);
    end
    tests_run++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_w1: got busy=%b done=%b cout=%b sum=%b, want all 0",
               busy1, done1, cout1, sum1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one 8-bit operation and checks result, latency, busy length,
  // sum stability during RUN and the return to idle.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic tc, input logic ts,
                      input logic [7:0] es, input logic ec, input string name);
    logic [7:0] prev_sum;
    int lat, busy_n;
    bit got, stable;
    prev_sum = sum8;
    a8 = ta; b8 = tb_v; cin8 = tc; sub8 = ts; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 'x; b8 = 'x; cin8 = 'x; sub8 = 'x;
    busy_n = busy8 ? 1 : 0;
    got = 0; lat = 0; stable = 1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (busy8) busy_n++;
      if (done8) begin
        got = 1; lat = i;
      end else if (sum8 !== prev_sum) begin
        stable = 0;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s_timeout: got no done within 40 cycles, want done", name);
    end
    tests_run++;
    if (sum8 !== es || cout8 !== ec) begin
      tests_failed++;
      $display("FAIL %s_result: got sum=%h cout=%b, want sum=%h cout=%b",
               name, sum8, cout8, es, ec);
    end
    tests_run++;
    if (lat != 8 || busy_n != 9) begin
      tests_failed++;
      $display("FAIL %s_timing: got latency=%0d busy_cycles=%0d, want 8 and 9",
               name, lat, busy_n);
    end
    tests_run++;
    if (!stable) begin
      tests_failed++;
      $display("FAIL %s_stable: got sum change during RUN, want held %h", name, prev_sum);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== es) begin
      tests_failed++;
      $display("FAIL %s_idle: got busy=%b done=%b sum=%h, want 0 0 %h",
               name, busy8, done8, sum8, es);
    end
    a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
  endtask

  task automatic test_add();
    run8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "add_5a_3c");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01");
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "add_ff_ff_c");
  endtask

  task automatic test_sub();
    run8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_10_01");
    run8(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, "sub_00_01");
  endtask

  task automatic test_back_to_back();
    bit got;
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk); #1;
    // Mid-RUN request with other operands.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done8) got = 1;
      else begin @(posedge clk); #1; end
    end
    tests_run++;
    if (!got || sum8 !== 8'h96 || cout8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: got done=%b sum=%h cout=%b, want 1 96 0",
               got, sum8, cout8);
    end
    // Request during the DONE cycle must be dropped.
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h96) begin
      tests_failed++;
      $display("FAIL b2b_done_ignored: got busy=%b done=%b sum=%h, want 0 0 96",
               busy8, done8, sum8);
    end
    // start still held on the cycle after done: accepted with these operands.
    a8 = 8'h03; b8 = 8'h04;
    @(posedge clk); #1;
    start8 = 1'b0;
    tests_run++;
    if (busy8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy8);
    end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done8) got = 1;
      else begin @(posedge clk); #1; end
    end
    tests_run++;
    if (!got || sum8 !== 8'h07 || cout8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: got done=%b sum=%h cout=%b, want 1 07 0",
               got, sum8, cout8);
    end
    @(posedge clk); #1;
    a8 = '0; b8 = '0;
  endtask

  task automatic test_reset_mid_run();
    a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy8, done8, cout8, sum8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "rerun_after_reset");
  endtask

  task automatic test_width1();
    logic [2:0] v;
    logic es, ec;
    int lat;
    bit got;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      es = v[2] ^ v[1] ^ v[0];
      ec = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 1'b0; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      got = 0; lat = 0;
      for (int i = 1; i <= 10 && !got; i++) begin
        @(posedge clk); #1;
        if (done1) begin got = 1; lat = i; end
      end
      tests_run++;
      if (!got || lat != 1 || sum1 !== es || cout1 !== ec) begin
        tests_failed++;
        $display("FAIL w1_abc_%b: got done=%b latency=%0d sum=%b cout=%b, want 1 1 %b %b",
                 v, got, lat, sum1, cout1, es, ec);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
